// File: rtl/id_scoreboard_pkg.sv
// Shared constants and types for the decode-stage register scoreboard.
// Counter width and GPR count live here so every file agrees on them.
package id_scoreboard_pkg;

  localparam int SB_CNT_W = 2;
  localparam int GPR_NUM  = 32;
  localparam int REG_AW   = $clog2(GPR_NUM);

  typedef logic [REG_AW-1:0] reg_idx_t;

endpackage

// File: rtl/id_scoreboard_cnt_slot.sv
// One per-register pending-write counter: saturating up/down.
// err pulses when an increment hits max or a decrement hits zero.
module sb_cnt_slot #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             err_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    err_o = 1'b0;
    if (inc_i & ~dec_i) begin
      if (cnt_q == CNT_MAX) err_o = 1'b1;
      else                  cnt_d = cnt_q + 1'b1;
    end else if (dec_i & ~inc_i) begin
      if (cnt_q == '0) err_o = 1'b1;
      else             cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/id_scoreboard.sv
// Decode-stage RAW scoreboard: counts in-flight GPR writes from issue to
// writeback and stalls decode while any used source is still pending.
module id_scoreboard
  import id_scoreboard_pkg::*;
#(
  parameter int CNT_W  = SB_CNT_W,
  parameter int PERF_W = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               ds_valid,
  input  logic               ds_fire,
  input  reg_idx_t           ds_raddr1,
  input  reg_idx_t           ds_raddr2,
  input  logic               ds_src1_used,
  input  logic               ds_src2_used,
  input  logic               ds_gr_we,
  input  reg_idx_t           ds_dest,
  input  logic               ws_retire,
  input  reg_idx_t           ws_dest,
  output logic               ds_stall,
  output logic [GPR_NUM-1:0] busy_mask,
  output logic               sb_err,
  output logic [PERF_W-1:0]  stall_cycles
);

  logic [GPR_NUM-1:0][CNT_W-1:0] cnt;
  logic [GPR_NUM-1:0]            err_v;

  assign cnt[0]   = '0;
  assign err_v[0] = 1'b0;

  for (genvar i = 1; i < GPR_NUM; i++) begin : g_slot
    logic inc;
    logic dec;
    assign inc = ds_fire & ds_gr_we & (ds_dest == REG_AW'(i));
    assign dec = ws_retire & (ws_dest == REG_AW'(i));
    sb_cnt_slot #(
      .CNT_W(CNT_W)
    ) u_slot (
      .clk    (clk),
      .resetn (resetn),
      .inc_i  (inc),
      .dec_i  (dec),
      .cnt_o  (cnt[i]),
      .err_o  (err_v[i])
    );
  end

  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < GPR_NUM; i++) begin
      busy_mask[i] = |cnt[i];
    end
  end

  // No bypass: a same-cycle retire still blocks until the regfile write lands.
  logic src1_busy;
  logic src2_busy;

  assign src1_busy = ds_src1_used & (|cnt[ds_raddr1]);
  assign src2_busy = ds_src2_used & (|cnt[ds_raddr2]);
  assign ds_stall  = ds_valid & (src1_busy | src2_busy);

  logic              sb_err_q;
  logic              sb_err_d;
  logic [PERF_W-1:0] perf_q;
  logic [PERF_W-1:0] perf_d;

  assign sb_err_d = sb_err_q | (|err_v);
  assign perf_d   = perf_q + PERF_W'(ds_valid & ds_stall);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sb_err_q <= 1'b0;
      perf_q   <= '0;
    end else begin
      sb_err_q <= sb_err_d;
      perf_q   <= perf_d;
    end
  end

  assign sb_err       = sb_err_q;
  assign stall_cycles = perf_q;

endmodule
